// File: rtl/srb_read_arbiter.sv
// srb_read_arbiter: shares the sparse read buffer's single read port among
// NUM_REQ requesters. Round-robin among requesters whose target entry is
// valid; one buffer read in flight at a time; the returned word is held in a
// response register until accepted. A per-requester watchdog turns a request
// for a never-valid entry into an error response.
module srb_read_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned SRB_DEPTH = 256,
   parameter int unsigned SRB_WIDTH = 8,
   parameter int unsigned TIMEOUT   = 64,
   localparam int unsigned PW       = $clog2(SRB_DEPTH),
   localparam int unsigned IDW      = $clog2(NUM_REQ),
   localparam int unsigned CW       = $clog2(TIMEOUT + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   input  logic [NUM_REQ*PW-1:0]   req_ptr_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   output logic                    rsp_valid_o,
   output logic [IDW-1:0]          rsp_id_o,
   output logic [SRB_WIDTH-1:0]    rsp_data_o,
   output logic                    rsp_err_o,
   input  logic                    rsp_ready_i,
   output logic                    srb_read_valid_o,
   output logic [PW-1:0]           srb_read_ptr_o,
   output logic                    srb_read_rtn_enable_o,
   input  logic                    srb_read_enable_i,
   input  logic                    srb_read_rtn_valid_i,
   input  logic [SRB_WIDTH-1:0]    srb_read_rtn_data_i,
   input  logic [SRB_DEPTH-1:0]    srb_sparse_array_valid_i
);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp
   } state_e;

   // FSM and registered outputs
   state_e                 state_q;
   logic [IDW-1:0]         rr_q;
   logic [IDW-1:0]         gnt_q;
   logic                   err_q;
   logic                   rd_valid_q;
   logic [PW-1:0]          rd_ptr_q;
   logic                   rtn_en_q;
   logic                   rsp_valid_q;
   logic [SRB_WIDTH-1:0]   rsp_data_q;
   logic                   rsp_err_q;

   // Watchdogs
   logic [CW-1:0]          wdog_q [NUM_REQ];
   logic [CW-1:0]          wdog_d [NUM_REQ];

   // Request decode
   logic [PW-1:0]          req_ptr_a [NUM_REQ];
   logic [NUM_REQ-1:0]     eligible;
   logic [NUM_REQ-1:0]     timed_out;
   logic [NUM_REQ-1:0]     cand;

   // Arbitration
   logic                   gnt_found;
   logic [IDW-1:0]         gnt_idx;
   logic                   gnt_err;
   logic [31:0]            scan;
   logic [IDW-1:0]         rr_next;

   // Handshake completing the ISSUE state this cycle
   logic                   take;

   // Split the packed pointer bus and flag requesters that can be served now
   always_comb begin
      eligible  = '0;
      timed_out = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_ptr_a[i] = req_ptr_i[i*PW +: PW];
         eligible[i]  = req_valid_i[i] & srb_sparse_array_valid_i[req_ptr_a[i]];
         timed_out[i] = req_valid_i[i] & (wdog_q[i] == CW'(TIMEOUT));
      end
      cand = eligible | timed_out;
   end

   // Round-robin pick: first candidate at or after rr_q, wrapping upward
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan = 32'(rr_q) + k;
         if (scan >= NUM_REQ) begin
            scan = scan - NUM_REQ;
         end
         if (!gnt_found && cand[scan[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan[IDW-1:0];
         end
      end
      // A timed-out requester whose entry has just become valid is served normally
      gnt_err = timed_out[gnt_idx] & ~eligible[gnt_idx];
   end

   // Next round-robin start is the requester after the current owner
   always_comb begin
      if (gnt_q == IDW'(NUM_REQ - 1)) begin
         rr_next = '0;
      end else begin
         rr_next = gnt_q + IDW'(1);
      end
   end

   // Accept pulse: an error grant completes at once, a real read on the buffer handshake
   always_comb begin
      take        = (state_q == StIssue) &
                    (err_q | (srb_read_enable_i & srb_read_rtn_valid_i));
      req_ready_o = '0;
      if (take) begin
         req_ready_o[gnt_q] = 1'b1;
      end
   end

   // Watchdog next state: count while waiting on an invalid entry, saturate at TIMEOUT
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         wdog_d[i] = wdog_q[i];
         if (!req_valid_i[i] || req_ready_o[i]) begin
            wdog_d[i] = '0;
         end else if (!eligible[i] && (wdog_q[i] != CW'(TIMEOUT))) begin
            wdog_d[i] = wdog_q[i] + CW'(1);
         end
      end
   end

   // Watchdog registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            wdog_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            wdog_q[i] <= wdog_d[i];
         end
      end
   end

   // Arbiter FSM with all buffer-side and response outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_q        <= '0;
         gnt_q       <= '0;
         err_q       <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_ptr_q    <= '0;
         rtn_en_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (gnt_found) begin
                  gnt_q      <= gnt_idx;
                  err_q      <= gnt_err;
                  // Error grants never touch the buffer
                  rd_valid_q <= ~gnt_err;
                  rtn_en_q   <= ~gnt_err;
                  rd_ptr_q   <= gnt_err ? '0 : req_ptr_a[gnt_idx];
                  state_q    <= StIssue;
               end
            end
            StIssue: begin
               if (take) begin
                  rsp_data_q  <= err_q ? '0 : srb_read_rtn_data_i;
                  rsp_err_q   <= err_q;
                  rsp_valid_q <= 1'b1;
                  rr_q        <= rr_next;
                  rd_valid_q  <= 1'b0;
                  rtn_en_q    <= 1'b0;
                  rd_ptr_q    <= '0;
                  state_q     <= StResp;
               end
            end
            StResp: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign rsp_valid_o           = rsp_valid_q;
   assign rsp_id_o              = gnt_q;
   assign rsp_data_o            = rsp_data_q;
   assign rsp_err_o             = rsp_err_q;
   assign srb_read_valid_o      = rd_valid_q;
   assign srb_read_ptr_o        = rd_ptr_q;
   assign srb_read_rtn_enable_o = rtn_en_q;

endmodule

// File: tb/tb_srb_read_arbiter.sv
// Directed bench for srb_read_arbiter with a small sparse-buffer model.
module tb_srb_read_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned PW = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [NR-1:0]  req_valid;
   logic [NR*PW-1:0] req_ptr;
   logic [NR-1:0]  req_ready;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [7:0]     rsp_data;
   logic           rsp_err;
   logic           rsp_ready;
   logic           srb_read_valid;
   logic [PW-1:0]  srb_read_ptr;
   logic           srb_read_rtn_enable;
   logic           ren;
   logic           rtn_valid;
   logic [7:0]     rtn_data;
   logic [255:0]   vbits;
   logic [7:0]     mem [256];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Buffer model: returns data whenever asked, entry cleared after a completed read
   assign rtn_valid = srb_read_valid;
   assign rtn_data  = mem[srb_read_ptr];

   srb_read_arbiter #(
      .NUM_REQ   (4),
      .SRB_DEPTH (256),
      .SRB_WIDTH (8),
      .TIMEOUT   (64)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .req_valid_i              (req_valid),
      .req_ptr_i                (req_ptr),
      .req_ready_o              (req_ready),
      .rsp_valid_o              (rsp_valid),
      .rsp_id_o                 (rsp_id),
      .rsp_data_o               (rsp_data),
      .rsp_err_o                (rsp_err),
      .rsp_ready_i              (rsp_ready),
      .srb_read_valid_o         (srb_read_valid),
      .srb_read_ptr_o           (srb_read_ptr),
      .srb_read_rtn_enable_o    (srb_read_rtn_enable),
      .srb_read_enable_i        (ren),
      .srb_read_rtn_valid_i     (rtn_valid),
      .srb_read_rtn_data_i      (rtn_data),
      .srb_sparse_array_valid_i (vbits)
   );

   // Requester protocol: pointer must not move while a request waits
   logic [NR-1:0]    prev_valid;
   logic [NR-1:0]    prev_ready;
   logic [NR*PW-1:0] prev_ptr;
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NR; i++) begin
            assert (!(prev_valid[i] && !prev_ready[i] && req_valid[i] &&
                      (req_ptr[i*PW +: PW] != prev_ptr[i*PW +: PW])))
               else $error("FAIL ptr_stable req %0d: ptr 0x%0h was 0x%0h", i,
                           req_ptr[i*PW +: PW], prev_ptr[i*PW +: PW]);
         end
      end
      prev_valid <= rst ? '0 : req_valid;
      prev_ready <= req_ready;
      prev_ptr   <= req_ptr;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock; the buffer model retires a completed read just after the edge
   task automatic cyc();
      logic       c;
      logic [7:0] p;
      c = srb_read_valid & ren & srb_read_rtn_enable & rtn_valid;
      p = srb_read_ptr;
      @(posedge clk);
      #1;
      if (c) vbits[p] = 1'b0;
   endtask

   task automatic expect_grant(input int id, input int ptr);
      cyc();
      check("grant_ready", 32'(req_ready), 32'(1) << id);
      check("grant_rd_valid", 32'(srb_read_valid), 32'd1);
      check("grant_rd_ptr", 32'(srb_read_ptr), 32'(ptr));
   endtask

   task automatic expect_rsp(input int id, input int data, input int err);
      cyc();
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_id", 32'(rsp_id), 32'(id));
      check("rsp_data", 32'(rsp_data), 32'(data));
      check("rsp_err", 32'(rsp_err), 32'(err));
      check("rsp_no_ready", 32'(req_ready), 32'd0);
      check("rsp_no_read", 32'(srb_read_valid), 32'd0);
   endtask

   task automatic set_ptr(input int id, input int ptr);
      req_ptr[id*PW +: PW] = 8'(ptr);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_ptr   = '0;
      rsp_ready = 1'b0;
      ren       = 1'b1;
      vbits     = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      cyc();
      cyc();

      // Reset state
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rd_valid", 32'(srb_read_valid), 32'd0);
      check("rst_rd_ptr", 32'(srb_read_ptr), 32'd0);
      check("rst_rtn_en", 32'(srb_read_rtn_enable), 32'd0);
      rst = 1'b0;
      cyc();

      // Single read: requester 2, entry 5 = 0xA3
      mem[5]   = 8'hA3;
      vbits[5] = 1'b1;
      set_ptr(2, 5);
      req_valid = 4'b0100;
      #1;
      check("idle_no_ready", 32'(req_ready), 32'd0);
      expect_grant(2, 5);
      check("single_rtn_en", 32'(srb_read_rtn_enable), 32'd1);
      expect_rsp(2, 8'hA3, 0);
      req_valid = '0;
      rsp_ready = 1'b1;
      cyc();
      check("single_rsp_drop", 32'(rsp_valid), 32'd0);

      // Backpressure: requester 0 (rr=3 wraps to 0), response held 10 cycles
      rsp_ready = 1'b0;
      mem[7]   = 8'h5C;
      vbits[7] = 1'b1;
      set_ptr(0, 7);
      req_valid = 4'b0001;
      expect_grant(0, 7);
      expect_rsp(0, 8'h5C, 0);
      req_valid = '0;
      mem[8]   = 8'h66;
      vbits[8] = 1'b1;
      set_ptr(1, 8);
      req_valid = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_id", 32'(rsp_id), 32'd0);
         check("bp_rsp_data", 32'(rsp_data), 32'h5C);
         check("bp_no_read", 32'(srb_read_valid), 32'd0);
      end

      // Asynchronous reset mid-RESP
      #3;
      rst       = 1'b1;
      req_valid = '0;
      #1;
      check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("arst_rsp_data", 32'(rsp_data), 32'd0);
      check("arst_rsp_id", 32'(rsp_id), 32'd0);
      check("arst_req_ready", 32'(req_ready), 32'd0);
      check("arst_rd_valid", 32'(srb_read_valid), 32'd0);
      cyc();
      rst = 1'b0;

      // Round-robin from rr=0: 0,1,2,3 then 0,1 again after wrap
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem[10+i]   = 8'(8'h10 + i);
         vbits[10+i] = 1'b1;
         set_ptr(i, 10 + i);
      end
      mem[14]   = 8'h14;
      mem[15]   = 8'h15;
      req_valid = 4'b1111;
      expect_grant(0, 10);
      expect_rsp(0, 8'h10, 0);
      set_ptr(0, 14);
      vbits[14] = 1'b1;
      cyc();
      check("rr_idle", 32'(rsp_valid), 32'd0);
      expect_grant(1, 11);
      expect_rsp(1, 8'h11, 0);
      set_ptr(1, 15);
      vbits[15] = 1'b1;
      cyc();
      expect_grant(2, 12);
      expect_rsp(2, 8'h12, 0);
      req_valid[2] = 1'b0;
      cyc();
      expect_grant(3, 13);
      expect_rsp(3, 8'h13, 0);
      req_valid[3] = 1'b0;
      cyc();
      expect_grant(0, 14);
      expect_rsp(0, 8'h14, 0);
      req_valid[0] = 1'b0;
      cyc();
      expect_grant(1, 15);
      expect_rsp(1, 8'h15, 0);
      req_valid[1] = 1'b0;
      cyc();

      // Timeout: requester 1 on never-valid entry 9
      set_ptr(1, 9);
      req_valid = 4'b0010;
      for (int i = 0; i < 64; i++) begin
         cyc();
         check("to_wait_ready", 32'(req_ready), 32'd0);
         check("to_wait_read", 32'(srb_read_valid), 32'd0);
      end
      cyc();
      check("to_grant_ready", 32'(req_ready), 32'b0010);
      check("to_grant_no_read", 32'(srb_read_valid), 32'd0);
      expect_rsp(1, 0, 1);
      req_valid = '0;
      cyc();

      // Skip-ineligible: requester 0 invalid entry 20, requester 3 valid entry 21
      mem[21]   = 8'h77;
      vbits[21] = 1'b1;
      set_ptr(0, 20);
      set_ptr(3, 21);
      req_valid = 4'b1001;
      expect_grant(3, 21);
      expect_rsp(3, 8'h77, 0);
      req_valid[3] = 1'b0;
      cyc();
      check("skip_idle_ready", 32'(req_ready), 32'd0);
      // Entry 20 becomes valid; buffer stalls two cycles first
      mem[20]   = 8'h55;
      vbits[20] = 1'b1;
      ren       = 1'b0;
      cyc();
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_rd_valid", 32'(srb_read_valid), 32'd1);
      cyc();
      check("stall_ready2", 32'(req_ready), 32'd0);
      check("stall_rd_ptr", 32'(srb_read_ptr), 32'd20);
      ren = 1'b1;
      #1;
      check("stall_release", 32'(req_ready), 32'b0001);
      expect_rsp(0, 8'h55, 0);
      req_valid = '0;
      cyc();
      check("end_idle", 32'(rsp_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
